imem_loader: RTL and testbench

- Parametrised instruction memory for the CPU fetch stage.
- Generalises the fixed 32-bit instruction ROM with width, depth and out-of-range handling set by parameters.
- Replaces the single-cycle write strobe with a streaming valid/ready load port that auto-increments the address.
- Memory clear runs as a cycle-by-cycle sweep, so the array can map to block RAM.
- Sits between the host/boot loader and the core: PC in, instruction out.

---
 rtl/imem_pkg.sv | 19 +
 rtl/imem_sram.sv | 30 +++
 rtl/imem_loader.sv | 184 ++++++++++++++++++
 tb/tb_imem_loader.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory loader.
//   imem_state_t       : controller state encoding (CLEAR, RUN, LOAD)
//   NOP_INST_DEFAULT   : default fill / out-of-range instruction
//   STALL_INST_DEFAULT : default instruction presented while busy
//   RST_ACTIVE         : level of rst_i that holds the block in reset
package imem_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_LOAD  = 2'd2
    } imem_state_t;

    localparam logic [31:0] NOP_INST_DEFAULT   = 32'h0000_0000;
    localparam logic [31:0] STALL_INST_DEFAULT = 32'hFFFF_FFFF;

    localparam logic RST_ACTIVE = 1'b0;

endpackage

// File: rtl/imem_sram.sv
// Single-port synchronous RAM with a one-cycle registered read.
// Read-first: a write and a read to the same address in one cycle
// return the old contents. No reset on the array so it maps to block RAM.
//   clk   : clock
//   we    : write enable
//   addr  : word address
//   wdata : write data
//   rdata : read data, mem[addr] sampled on the previous clock edge
module imem_sram #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 1024,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/imem_loader.sv
// Parametrised instruction memory for the fetch stage with a streaming
// valid/ready load port and a cycle-by-cycle clear sweep.
//   clk_i, rst_i              : clock, asynchronous active-low reset
//   pc_i, fetch_en_i          : fetch request
//   inst_o, inst_valid_o      : fetched instruction, one cycle after request
//   oob_o                     : last fetch addressed beyond DEPTH
//   clr_i                     : soft-clear request
//   ld_start_i, ld_base_i     : start a load burst at ld_base_i mod DEPTH
//   ld_valid_i, ld_data_i,
//   ld_last_i, ld_ready_o     : load word handshake, last-word marker
//   ld_wrap_o                 : load pointer wrapped since last ld_start_i
//   busy_o                    : in CLEAR or LOAD
//
// state | meaning
// ------+---------------------------------------------------------------
// CLEAR | sweep NOP into every word, one per cycle; requests ignored
// RUN   | serve fetches; accept clr / load start (clr > load > fetch)
// LOAD  | ld_ready_o high, write each handshaken word, exit on last word
module imem_loader
    import imem_pkg::*;
#(
    parameter int          DATA_W     = 32,
    parameter int          ADDR_W     = 16,
    parameter int          DEPTH      = 1024,
    parameter logic [31:0] NOP_INST   = NOP_INST_DEFAULT,
    parameter logic [31:0] STALL_INST = STALL_INST_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              fetch_en_i,
    output logic [DATA_W-1:0] inst_o,
    output logic              inst_valid_o,
    output logic              oob_o,
    input  logic              clr_i,
    input  logic              ld_start_i,
    input  logic [ADDR_W-1:0] ld_base_i,
    input  logic              ld_valid_i,
    input  logic [DATA_W-1:0] ld_data_i,
    input  logic              ld_last_i,
    output logic              ld_ready_o,
    output logic              ld_wrap_o,
    output logic              busy_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = ADDR_W + 1;

    localparam logic [DATA_W-1:0] NOP_W   = DATA_W'(NOP_INST);
    localparam logic [DATA_W-1:0] STALL_W = DATA_W'(STALL_INST);
    localparam logic [PTR_W-1:0]  DEPTH_P = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0]  LAST_P  = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);

    imem_state_t       state;
    logic [PTR_W-1:0]  ptr;
    logic [DATA_W-1:0] inst_q;
    logic              out_sel;   // inst_o comes straight from the RAM read port

    logic              pc_oob;
    logic              ld_fire;
    logic              ram_we;
    logic [IDX_W-1:0]  ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    assign pc_oob  = {1'b0, pc_i} >= DEPTH_P;
    assign ld_fire = (state == ST_LOAD) && ld_valid_i && ld_ready_o;

    // The RAM read register already provides the one-cycle fetch latency,
    // so inst_o selects it for the cycle after an in-range fetch; inst_q
    // captures that word afterwards so inst_o holds while the RAM address
    // keeps following pc_i.
    assign inst_o = out_sel ? ram_rdata : inst_q;

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = pc_i[IDX_W-1:0];
        ram_wdata = ld_data_i;
        case (state)
            ST_CLEAR: begin
                ram_we    = 1'b1;
                ram_addr  = ptr[IDX_W-1:0];
                ram_wdata = NOP_W;
            end
            ST_LOAD: begin
                ram_we   = ld_fire;
                ram_addr = ptr[IDX_W-1:0];
            end
            default: ;
        endcase
    end

    imem_sram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_sram (
        .clk    (clk_i),
        .we     (ram_we),
        .addr   (ram_addr),
        .wdata  (ram_wdata),
        .rdata  (ram_rdata)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (rst_i == RST_ACTIVE) begin
            state        <= ST_CLEAR;
            ptr          <= '0;
            inst_q       <= NOP_W;
            out_sel      <= 1'b0;
            inst_valid_o <= 1'b0;
            oob_o        <= 1'b0;
            ld_ready_o   <= 1'b0;
            ld_wrap_o    <= 1'b0;
            busy_o       <= 1'b1;
        end else begin
            case (state)
                ST_CLEAR: begin
                    inst_q       <= STALL_W;
                    out_sel      <= 1'b0;
                    inst_valid_o <= 1'b0;
                    if (ptr == LAST_P) begin
                        ptr    <= '0;
                        state  <= ST_RUN;
                        busy_o <= 1'b0;
                    end else begin
                        ptr <= ptr + PTR_ONE;
                    end
                end

                ST_RUN: begin
                    if (out_sel) begin
                        inst_q <= ram_rdata;
                    end
                    out_sel      <= 1'b0;
                    inst_valid_o <= 1'b0;
                    if (clr_i) begin
                        ptr    <= '0;
                        state  <= ST_CLEAR;
                        busy_o <= 1'b1;
                        inst_q <= STALL_W;
                    end else if (ld_start_i) begin
                        ptr        <= {1'b0, ld_base_i} % DEPTH_P;
                        ld_wrap_o  <= 1'b0;
                        ld_ready_o <= 1'b1;
                        busy_o     <= 1'b1;
                        state      <= ST_LOAD;
                        inst_q     <= STALL_W;
                    end else if (fetch_en_i) begin
                        inst_valid_o <= 1'b1;
                        oob_o        <= pc_oob;
                        if (pc_oob) begin
                            inst_q <= NOP_W;
                        end else begin
                            out_sel <= 1'b1;
                        end
                    end
                end

                ST_LOAD: begin
                    if (ld_fire) begin
                        if (ptr == LAST_P) begin
                            ptr       <= '0;
                            ld_wrap_o <= 1'b1;
                        end else begin
                            ptr <= ptr + PTR_ONE;
                        end
                        if (ld_last_i) begin
                            ld_ready_o <= 1'b0;
                            busy_o     <= 1'b0;
                            state      <= ST_RUN;
                        end
                    end
                end

                default: begin
                    state <= ST_CLEAR;
                    ptr   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized fetch/load traffic
// against an array model of the memory contents.
module tb_imem_loader;

    localparam int          DEPTH = 1024;
    localparam int          AW    = 16;
    localparam logic [31:0] NOP   = 32'h0000_0000;
    localparam logic [31:0] STALL = 32'hFFFF_FFFF;

    logic        clk;
    logic        rst_i;
    logic [15:0] pc_i;
    logic        fetch_en_i;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        oob_o;
    logic        clr_i;
    logic        ld_start_i;
    logic [15:0] ld_base_i;
    logic        ld_valid_i;
    logic [31:0] ld_data_i;
    logic        ld_last_i;
    logic        ld_ready_o;
    logic        ld_wrap_o;
    logic        busy_o;

    imem_loader #(
        .DATA_W (32),
        .ADDR_W (AW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .pc_i         (pc_i),
        .fetch_en_i   (fetch_en_i),
        .inst_o       (inst_o),
        .inst_valid_o (inst_valid_o),
        .oob_o        (oob_o),
        .clr_i        (clr_i),
        .ld_start_i   (ld_start_i),
        .ld_base_i    (ld_base_i),
        .ld_valid_i   (ld_valid_i),
        .ld_data_i    (ld_data_i),
        .ld_last_i    (ld_last_i),
        .ld_ready_o   (ld_ready_o),
        .ld_wrap_o    (ld_wrap_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] model_mem [DEPTH];
    bit          exp_wrap;
    logic [31:0] ld_q [$];

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        fetch_en_i = 1'b0;
        clr_i      = 1'b0;
        ld_start_i = 1'b0;
        ld_valid_i = 1'b0;
        ld_last_i  = 1'b0;
    endtask

    task automatic model_clear;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = NOP;
    endtask

    // Counts cycles until busy_o drops while throwing random requests that
    // must all be ignored.
    task automatic wait_clear(input string tag);
        int cnt;
        bit bad;
        cnt = 0;
        bad = 1'b0;
        while (busy_o && cnt < 2000) begin
            fetch_en_i = 1'($urandom_range(0, 1));
            clr_i      = 1'($urandom_range(0, 1));
            ld_start_i = 1'($urandom_range(0, 1));
            ld_valid_i = 1'($urandom_range(0, 1));
            pc_i       = 16'($urandom);
            ld_base_i  = 16'($urandom);
            ld_data_i  = $urandom;
            tick;
            cnt++;
            if (inst_valid_o || ld_ready_o || inst_o !== STALL) bad = 1'b1;
        end
        idle_inputs;
        chk({tag, "_clear_len"}, 64'(cnt), 64'd1024);
        chk({tag, "_clear_quiet"}, 64'(bad), 64'd0);
        chk({tag, "_clear_busy"}, 64'(busy_o), 64'd0);
    endtask

    task automatic do_fetch(input int pc);
        logic [31:0] e;
        bit          eo;
        eo = (pc >= DEPTH);
        e  = eo ? NOP : model_mem[pc];
        pc_i = 16'(pc);
        fetch_en_i = 1'b1;
        tick;
        fetch_en_i = 1'b0;
        chk($sformatf("fetch_data_%0d", pc), 64'(inst_o), 64'(e));
        chk($sformatf("fetch_valid_%0d", pc), 64'(inst_valid_o), 64'd1);
        chk($sformatf("fetch_oob_%0d", pc), 64'(oob_o), 64'(eo));
        pc_i = 16'($urandom);
        tick;
        chk($sformatf("hold_data_%0d", pc), 64'(inst_o), 64'(e));
        chk($sformatf("hold_valid_%0d", pc), 64'(inst_valid_o), 64'd0);
        chk($sformatf("hold_oob_%0d", pc), 64'(oob_o), 64'(eo));
    endtask

    // Streams ld_q starting at base; alt_gap inserts exactly one idle cycle
    // before each word, otherwise 0..2 random idle cycles with noise.
    task automatic do_load(input int base, input bit alt_gap);
        int p;
        int gap;
        bit bad;
        ld_base_i  = 16'(base);
        ld_start_i = 1'b1;
        tick;
        ld_start_i = 1'b0;
        chk("ld_enter_ready", 64'(ld_ready_o), 64'd1);
        chk("ld_enter_busy", 64'(busy_o), 64'd1);
        chk("ld_enter_wrap", 64'(ld_wrap_o), 64'd0);
        chk("ld_enter_inst", 64'(inst_o), 64'(STALL));
        exp_wrap = 1'b0;
        p   = base % DEPTH;
        bad = 1'b0;
        for (int i = 0; i < ld_q.size(); i++) begin
            gap = alt_gap ? 1 : int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                ld_valid_i = 1'b0;
                ld_last_i  = 1'($urandom_range(0, 1));
                fetch_en_i = 1'($urandom_range(0, 1));
                clr_i      = 1'($urandom_range(0, 1));
                ld_start_i = 1'($urandom_range(0, 1));
                pc_i       = 16'($urandom);
                ld_base_i  = 16'($urandom);
                ld_data_i  = $urandom;
                tick;
                if (!ld_ready_o || !busy_o || inst_valid_o || inst_o !== STALL) bad = 1'b1;
            end
            fetch_en_i = 1'b0;
            clr_i      = 1'b0;
            ld_start_i = 1'b0;
            ld_valid_i = 1'b1;
            ld_data_i  = ld_q[i];
            ld_last_i  = (i == ld_q.size() - 1);
            tick;
            model_mem[p] = ld_q[i];
            if (p == DEPTH - 1) begin
                p = 0;
                exp_wrap = 1'b1;
            end else begin
                p++;
            end
            if (i != ld_q.size() - 1 && (!ld_ready_o || !busy_o)) bad = 1'b1;
        end
        ld_valid_i = 1'b0;
        ld_last_i  = 1'b0;
        chk("ld_stream", 64'(bad), 64'd0);
        chk("ld_exit_ready", 64'(ld_ready_o), 64'd0);
        chk("ld_exit_busy", 64'(busy_o), 64'd0);
        chk("ld_exit_wrap", 64'(ld_wrap_o), 64'(exp_wrap));
    endtask

    initial begin
        int base;
        int len;
        rst_i = 1'b0;
        pc_i = '0;
        ld_base_i = '0;
        ld_data_i = '0;
        idle_inputs;
        exp_wrap = 1'b0;
        model_clear;

        repeat (3) tick;
        chk("rst_inst", 64'(inst_o), 64'(NOP));
        chk("rst_valid", 64'(inst_valid_o), 64'd0);
        chk("rst_oob", 64'(oob_o), 64'd0);
        chk("rst_ready", 64'(ld_ready_o), 64'd0);
        chk("rst_wrap", 64'(ld_wrap_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd1);

        #2 rst_i = 1'b1;
        wait_clear("boot");
        do_fetch(5);

        ld_q = '{32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 32'hA000_0004};
        do_load(16'h10, 1'b1);
        for (int a = 16'h10; a <= 16'h13; a++) do_fetch(a);
        chk("ld1_wrap", 64'(ld_wrap_o), 64'd0);

        ld_q = '{$urandom, $urandom, $urandom};
        do_load(1022, 1'b0);
        chk("ld2_wrap_set", 64'(ld_wrap_o), 64'd1);
        do_fetch(1022);
        do_fetch(1023);
        do_fetch(0);
        chk("ld2_wrap_sticky", 64'(ld_wrap_o), 64'd1);

        ld_q = '{$urandom};
        do_load(100, 1'b0);
        do_fetch(100);

        do_fetch(2000);
        do_fetch(3);

        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 3) == 0)
                    base = int'($urandom_range(DEPTH - 4, DEPTH - 1)) + DEPTH * int'($urandom_range(0, 63));
                else
                    base = int'($urandom_range(0, 65535));
                len = int'($urandom_range(1, 6));
                ld_q.delete();
                for (int k = 0; k < len; k++) ld_q.push_back($urandom);
                do_load(base, 1'b0);
                do_fetch(base % DEPTH);
            end else if ($urandom_range(0, 4) == 0) begin
                do_fetch(int'($urandom_range(DEPTH, 65535)));
            end else begin
                do_fetch(int'($urandom_range(0, DEPTH - 1)));
            end
        end

        pc_i       = 16'h10;
        ld_base_i  = 16'd300;
        clr_i      = 1'b1;
        ld_start_i = 1'b1;
        fetch_en_i = 1'b1;
        tick;
        idle_inputs;
        chk("coin_busy", 64'(busy_o), 64'd1);
        chk("coin_ready", 64'(ld_ready_o), 64'd0);
        chk("coin_valid", 64'(inst_valid_o), 64'd0);
        chk("coin_inst", 64'(inst_o), 64'(STALL));
        wait_clear("coin");
        model_clear;
        do_fetch(16'h10);
        do_fetch(1022);
        do_fetch(0);

        ld_base_i  = 16'd200;
        ld_start_i = 1'b1;
        tick;
        ld_start_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            ld_valid_i = 1'b1;
            ld_data_i  = $urandom | 32'h1;
            tick;
        end
        ld_valid_i = 1'b0;
        chk("mid_ld_ready", 64'(ld_ready_o), 64'd1);
        #2 rst_i = 1'b0;
        #1;
        chk("arst_inst", 64'(inst_o), 64'(NOP));
        chk("arst_ready", 64'(ld_ready_o), 64'd0);
        chk("arst_busy", 64'(busy_o), 64'd1);
        chk("arst_wrap", 64'(ld_wrap_o), 64'd0);
        tick;
        tick;
        #2 rst_i = 1'b1;
        wait_clear("arst");
        model_clear;
        do_fetch(200);
        do_fetch(201);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
